upto5_monitor: RTL and testbench
================================

UPTO5_MONITOR -- requirements
Module: upto5_monitor

Interface
REQ-001 clk  input  1  single rising-edge clock, shared with the monitored 0..5 counter.
REQ-002 R  input  1  asynchronous active-high reset.
REQ-003 M  input  1  counter mode as driven to the counter: 1 = up, 0 = down.
REQ-004 Q  input  3  counter value, Q[0] = LSB; legal range 0..5.
REQ-005 cout  input  1  counter terminal flag.
REQ-006 locked  output  1  high while the monitor tracks a consistent sequence.
REQ-007 err  output  1  one-cycle pulse on each detected mismatch.
REQ-008 err_cnt  output  8  saturating count of err pulses.
REQ-009 wrap_cnt  output  8  modulo-256 count of verified wrap events (5->0 up, 0->5 down).
REQ-010 exp_q  output  3  value predicted for the current cycle; 0 when not LOCKED.

Function
REQ-011 The monitor SHALL register M, Q and cout once (sample stage); all checks SHALL use the sampled values, so err rises 1 cycle after the offending edge.
REQ-012 The FSM SHALL have states IDLE, ACQ, LOCKED and FAULT.
REQ-013 IDLE: on the first sampled legal Q (0..5), store it as prev and go to ACQ.
REQ-014 ACQ: next = prev+1 mod 6 if sampled M=1, else prev-1 mod 6.
REQ-015 ACQ: a sample equal to next SHALL increment a 2-bit match counter; when the counter reaches 2, go to LOCKED.
REQ-016 ACQ: any mismatch SHALL reload prev from the sample and clear the match counter, with no err pulse.
REQ-017 LOCKED: each sample SHALL be compared to exp_q; on mismatch, pulse err, then resynchronise prev from the sample.
REQ-018 LOCKED: 4 consecutive mismatches SHALL move the FSM to FAULT.
REQ-019 Any sampled Q of 6 or 7 SHALL pulse err, in any state except IDLE, and move to FAULT.
REQ-020 FAULT: locked=0; leave only after 3 consecutive matching predictions, into ACQ with the match counter cleared.
REQ-021 Mode change: the prediction SHALL use the M sampled in the same cycle as the previous Q, so a change of M on any edge is legal and never itself an error.
REQ-022 wrap_cnt SHALL increment only in LOCKED, on a matching 5->0 (M=1) or 0->5 (M=0) transition; it wraps 255->0.
REQ-023 err_cnt SHALL saturate at 255.
REQ-024 Simultaneous err and wrap SHALL be impossible, because a wrap requires a match.
REQ-025 locked SHALL be high exactly while the state is LOCKED.

Reset
REQ-026 R high SHALL immediately force state IDLE, locked=0, err=0, err_cnt=0, wrap_cnt=0, exp_q=0, and clear the sample registers and match/mismatch counters.
REQ-027 R asserted mid-sequence SHALL discard all history; after deassertion, acquisition restarts from IDLE.
REQ-028 Reset deassertion SHALL take effect at the first rising clk edge with R low; no check SHALL be made on that edge.

Configuration
REQ-029 Macro UPTO5_MONITOR_COUT_CHK_EN: when defined, in LOCKED the sampled cout SHALL be required to equal (sampled Q==5); a violation pulses err (counted once per cycle even when Q also mismatches) but does not affect the mismatch run or the state.
REQ-030 Without UPTO5_MONITOR_COUT_CHK_EN, cout SHALL be ignored and its logic absent.

Verification
REQ-031 Reset then M=1, Q=0,1,2,3,4,5,0 -> locked rises after the 3rd sampled value; wrap_cnt=1 after 5->0; err never pulses.
REQ-032 Locked, counting up, Q=2,3,1,2 -> one err pulse 1 cycle after Q=1 is sampled; err_cnt=1; locked stays 1.
REQ-033 Locked, M switches to 0 at Q=3, next Q=2,1,0,5 -> no err; wrap_cnt increments on 0->5.
REQ-034 Locked, Q=6 sampled -> err pulse, state FAULT, locked=0; then 3 correct steps -> ACQ; 2 more -> LOCKED.
REQ-035 Locked, R pulsed high for half a cycle mid-count -> all outputs 0 immediately; relock needs 3 fresh samples.
REQ-036 With UPTO5_MONITOR_COUT_CHK_EN: locked, Q=5 with cout=0 -> one err pulse, err_cnt +1, locked stays 1; without the macro -> no err.

Source files
------------

// File: rtl/upto5_monitor.sv
// rtl/upto5_monitor.sv - sequence monitor for a 0..5 up/down counter
// Optional cout consistency check: UPTO5_MONITOR_COUT_CHK_EN
module upto5_monitor (
   input  logic       clk,
   input  logic       R,
   input  logic       M,
   input  logic [2:0] Q,
   input  logic       cout,
   output logic       locked,
   output logic       err,
   output logic [7:0] err_cnt,
   output logic [7:0] wrap_cnt,
   output logic [2:0] exp_q
);

   typedef enum logic [1:0] {IDLE, ACQ, LOCKED, FAULT} state_t;

   state_t     r_state;
   logic       r_vld;
   logic       r_m;
   logic [2:0] r_q;
   logic [2:0] r_prev;
   logic       r_prev_m;
   logic [1:0] r_match;
   logic [2:0] r_miss;
   logic       r_err;
   logic [7:0] r_err_cnt;
   logic [7:0] r_wrap_cnt;

   logic [2:0] w_next;
   logic       w_legal;
   logic       w_hit;
   logic       w_wrap;
   logic       w_cout_bad;
   logic       w_err;

   // Out-of-range prev (after an illegal sample) still yields a legal prediction.
   function automatic logic [2:0] f_step(input logic [2:0] p, input logic up);
      logic [2:0] n;
      if (up)
         n = (p >= 3'd5) ? 3'd0 : p + 3'd1;
      else
         n = (p == 3'd0 || p > 3'd5) ? 3'd5 : p - 3'd1;
      return n;
   endfunction

   assign w_next  = f_step(r_prev, r_prev_m);
   assign w_legal = (r_q <= 3'd5);
   assign w_hit   = (r_q == w_next);
   assign w_wrap  = w_hit && ((r_prev == 3'd5 && r_prev_m) || (r_prev == 3'd0 && !r_prev_m));

`ifdef UPTO5_MONITOR_COUT_CHK_EN
   logic r_cout;
   assign w_cout_bad = (r_state == LOCKED) && (r_cout != (r_q == 3'd5));
`else
   logic w_unused_cout;
   assign w_unused_cout = cout;
   assign w_cout_bad    = 1'b0;
`endif

   assign w_err = r_vld && (r_state != IDLE) &&
                  (!w_legal || (r_state == LOCKED && !w_hit) || w_cout_bad);

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         r_state    <= IDLE;
         r_vld      <= 1'b0;
         r_m        <= 1'b0;
         r_q        <= 3'd0;
         r_prev     <= 3'd0;
         r_prev_m   <= 1'b0;
         r_match    <= 2'd0;
         r_miss     <= 3'd0;
         r_err      <= 1'b0;
         r_err_cnt  <= 8'd0;
         r_wrap_cnt <= 8'd0;
`ifdef UPTO5_MONITOR_COUT_CHK_EN
         r_cout     <= 1'b0;
`endif
      end else begin
         r_vld <= 1'b1;
         r_q   <= Q;
         r_m   <= M;
`ifdef UPTO5_MONITOR_COUT_CHK_EN
         r_cout <= cout;
`endif
         r_err <= w_err;
         if (w_err && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;

         // The first edge after reset only fills the sample stage.
         if (r_vld) begin
            r_prev   <= r_q;
            r_prev_m <= r_m;
            case (r_state)
               IDLE: begin
                  if (w_legal) begin
                     r_match <= 2'd0;
                     r_state <= ACQ;
                  end
               end
               ACQ: begin
                  if (!w_legal) begin
                     r_match <= 2'd0;
                     r_state <= FAULT;
                  end else if (w_hit) begin
                     if (r_match == 2'd1) begin
                        r_match <= 2'd0;
                        r_miss  <= 3'd0;
                        r_state <= LOCKED;
                     end else begin
                        r_match <= r_match + 2'd1;
                     end
                  end else begin
                     r_match <= 2'd0;
                  end
               end
               LOCKED: begin
                  if (!w_legal) begin
                     r_match <= 2'd0;
                     r_state <= FAULT;
                  end else if (w_hit) begin
                     r_miss <= 3'd0;
                     if (w_wrap)
                        r_wrap_cnt <= r_wrap_cnt + 8'd1;
                  end else if (r_miss == 3'd3) begin
                     r_match <= 2'd0;
                     r_state <= FAULT;
                  end else begin
                     r_miss <= r_miss + 3'd1;
                  end
               end
               FAULT: begin
                  if (w_hit) begin
                     if (r_match == 2'd2) begin
                        r_match <= 2'd0;
                        r_state <= ACQ;
                     end else begin
                        r_match <= r_match + 2'd1;
                     end
                  end else begin
                     r_match <= 2'd0;
                  end
               end
            endcase
         end
      end
   end

   assign locked   = (r_state == LOCKED);
   assign err      = r_err;
   assign err_cnt  = r_err_cnt;
   assign wrap_cnt = r_wrap_cnt;
   assign exp_q    = (r_state == LOCKED) ? w_next : 3'd0;

endmodule

// File: tb/tb_upto5_monitor.sv
// tb/tb_upto5_monitor.sv - directed scoreboard bench for upto5_monitor
module tb_upto5_monitor;

   logic       clk = 1'b0;
   logic       R = 1'b1;
   logic       M = 1'b1;
   logic [2:0] Q = 3'd0;
   logic       cout = 1'b0;
   logic       locked, err;
   logic [7:0] err_cnt, wrap_cnt;
   logic [2:0] exp_q;

   int checks = 0;
   int errors = 0;

`ifdef UPTO5_MONITOR_COUT_CHK_EN
   localparam logic CE = 1'b1;
`else
   localparam logic CE = 1'b0;
`endif

   typedef struct {
      logic       err;
      logic       lck;
      logic [2:0] eq;
      logic [7:0] wr;
      logic [7:0] ec;
      string      tag;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] e_cnt = 8'd0;
   logic [7:0] w_cnt = 8'd0;

   upto5_monitor dut (
      .clk(clk), .R(R), .M(M), .Q(Q), .cout(cout),
      .locked(locked), .err(err), .err_cnt(err_cnt),
      .wrap_cnt(wrap_cnt), .exp_q(exp_q)
   );

   always #5 clk = ~clk;

   task automatic compare(input exp_t e);
      checks++;
      assert (err === e.err) else begin
         errors++; $error("FAIL %s err observed=%0b expected=%0b", e.tag, err, e.err);
      end
      checks++;
      assert (locked === e.lck) else begin
         errors++; $error("FAIL %s locked observed=%0b expected=%0b", e.tag, locked, e.lck);
      end
      checks++;
      assert (exp_q === e.eq) else begin
         errors++; $error("FAIL %s exp_q observed=%0d expected=%0d", e.tag, exp_q, e.eq);
      end
      checks++;
      assert (wrap_cnt === e.wr) else begin
         errors++; $error("FAIL %s wrap_cnt observed=%0d expected=%0d", e.tag, wrap_cnt, e.wr);
      end
      checks++;
      assert (err_cnt === e.ec) else begin
         errors++; $error("FAIL %s err_cnt observed=%0d expected=%0d", e.tag, err_cnt, e.ec);
      end
   endtask

   // Expected outputs after the driven sample has been processed (two edges later).
   task automatic expect_only(input logic e_err, input logic e_lck, input logic [2:0] e_eq,
                              input logic wv, input string tag);
      exp_t e;
      if (e_err && e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
      if (wv) w_cnt = w_cnt + 8'd1;
      e.err = e_err; e.lck = e_lck; e.eq = e_eq; e.wr = w_cnt; e.ec = e_cnt; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic step(input logic [2:0] q, input logic m, input logic c,
                       input logic e_err, input logic e_lck, input logic [2:0] e_eq,
                       input logic wv, input string tag);
      Q = q; M = m; cout = c;
      expect_only(e_err, e_lck, e_eq, wv, tag);
      @(posedge clk);
      @(negedge clk);
      if (sb.size() > 1) compare(sb.pop_front());
   endtask

   task automatic drain();
      @(posedge clk);
      @(negedge clk);
      if (sb.size() > 0) compare(sb.pop_front());
   endtask

   initial begin
      exp_t z;
      z.err = 1'b0; z.lck = 1'b0; z.eq = 3'd0; z.wr = 8'd0; z.ec = 8'd0;

      repeat (2) @(negedge clk);
      z.tag = "reset";
      compare(z);
      R = 1'b0;

      // Count up from 0, lock on the 3rd sample, wrap 5->0
      step(3'd0, 1, 0, 0, 0, 3'd0, 0, "up_q0");
      step(3'd1, 1, 0, 0, 0, 3'd0, 0, "up_q1");
      step(3'd2, 1, 0, 0, 1, 3'd3, 0, "lock");
      step(3'd3, 1, 0, 0, 1, 3'd4, 0, "up_q3");
      step(3'd4, 1, 0, 0, 1, 3'd5, 0, "up_q4");
      step(3'd5, 1, 1, 0, 1, 3'd0, 0, "up_q5");
      step(3'd0, 1, 0, 0, 1, 3'd1, 1, "wrap_up");
      step(3'd1, 1, 0, 0, 1, 3'd2, 0, "up_q1b");
      step(3'd2, 1, 0, 0, 1, 3'd3, 0, "up_q2b");
      step(3'd3, 1, 0, 0, 1, 3'd4, 0, "up_q3b");
      step(3'd1, 1, 0, 1, 1, 3'd2, 0, "skip_err");
      step(3'd2, 1, 0, 0, 1, 3'd3, 0, "resync");
      // Direction change, wrap 0->5 down
      step(3'd3, 0, 0, 0, 1, 3'd2, 0, "mode_dn");
      step(3'd2, 0, 0, 0, 1, 3'd1, 0, "dn_q2");
      step(3'd1, 0, 0, 0, 1, 3'd0, 0, "dn_q1");
      step(3'd0, 0, 0, 0, 1, 3'd5, 0, "dn_q0");
      step(3'd5, 0, 1, 0, 1, 3'd4, 1, "wrap_dn");
      step(3'd4, 1, 0, 0, 1, 3'd5, 0, "mode_up");
      step(3'd5, 1, 0, CE, 1, 3'd0, 0, "cout_chk");
      step(3'd0, 1, 0, 0, 1, 3'd1, 1, "wrap_up2");
      // Mismatch run broken by a match, then 4 in a row -> FAULT
      step(3'd3, 1, 0, 1, 1, 3'd4, 0, "miss1");
      step(3'd3, 1, 0, 1, 1, 3'd4, 0, "miss2");
      step(3'd3, 1, 0, 1, 1, 3'd4, 0, "miss3");
      step(3'd4, 1, 0, 0, 1, 3'd5, 0, "run_reset");
      step(3'd0, 1, 0, 1, 1, 3'd1, 0, "miss1b");
      step(3'd0, 1, 0, 1, 1, 3'd1, 0, "miss2b");
      step(3'd0, 1, 0, 1, 1, 3'd1, 0, "miss3b");
      step(3'd0, 1, 0, 1, 0, 3'd0, 0, "fault4");
      step(3'd1, 1, 0, 0, 0, 3'd0, 0, "flt_m1");
      step(3'd2, 1, 0, 0, 0, 3'd0, 0, "flt_m2");
      step(3'd3, 1, 0, 0, 0, 3'd0, 0, "flt_to_acq");
      step(3'd4, 1, 0, 0, 0, 3'd0, 0, "acq_m1");
      step(3'd5, 1, 1, 0, 1, 3'd0, 0, "relock");
      // Illegal value while locked
      step(3'd6, 1, 0, 1, 0, 3'd0, 0, "illegal6");
      step(3'd3, 1, 0, 0, 0, 3'd0, 0, "flt_resync");
      step(3'd4, 1, 0, 0, 0, 3'd0, 0, "flt_h1");
      step(3'd5, 1, 1, 0, 0, 3'd0, 0, "flt_h2");
      step(3'd0, 1, 0, 0, 0, 3'd0, 0, "flt_nowrap");
      step(3'd1, 1, 0, 0, 0, 3'd0, 0, "acq_h1");
      step(3'd2, 1, 0, 0, 1, 3'd3, 0, "fault_relock");
      step(3'd3, 1, 0, 0, 1, 3'd4, 0, "pre_rst");

      // Half-cycle reset pulse mid-count
      R = 1'b1;
      #1;
      z.tag = "async_rst";
      compare(z);
      sb.delete();
      e_cnt = 8'd0;
      w_cnt = 8'd0;
      Q = 3'd7;
      #3 R = 1'b0;
      @(negedge clk);
      expect_only(0, 0, 3'd0, 0, "idle_ign7");
      step(3'd2, 1, 0, 0, 0, 3'd0, 0, "rst_q2");
      step(3'd3, 1, 0, 0, 0, 3'd0, 0, "rst_q3");
      step(3'd4, 1, 0, 0, 1, 3'd5, 0, "rst_relock");

      // 256 wraps: wrap_cnt must roll through 255 back to 0
      for (int i = 0; i < 256; i++) begin
         for (int k = 0; k < 6; k++) begin
            logic [2:0] q;
            q = (k == 0) ? 3'd5 : 3'(k - 1);
            step(q, 1, q == 3'd5, 0, 1, (q == 3'd5) ? 3'd0 : q + 3'd1, q == 3'd0, "wrap_loop");
         end
      end

      // Illegal samples in FAULT keep pulsing err; err_cnt saturates
      step(3'd7, 1, 0, 1, 0, 3'd0, 0, "illegal7");
      for (int i = 0; i < 260; i++)
         step(3'd6, 1, 0, 1, 0, 3'd0, 0, "err_sat");
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
